// File: rtl/hwpe_ctrl_offloader.sv
// rtl/hwpe_ctrl_offloader.sv - offloads one job to an HWPE over its peripheral control bus
//
// Runs one job at a time on an HWPE. It acquires a job slot, with bounded
// retries and a fixed backoff between attempts. It then writes the per-job IO
// registers into the granted context, triggers the job, and waits for the
// end-of-job event. Finally it reads FINISHED to retire the job and reports
// completion.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous clear, same effect as reset
//   job_valid_i          job request (accepted only when job_ready_o is high)
//   job_ready_o          high only while idle
//   job_params_i         N_IO_REGS 32-bit IO register values, word k at [32k+31:32k]
//   evt_i                HWPE end-of-job event pulse
//   job_done_o           one-cycle completion pulse
//   job_err_o            valid with job_done_o, 1 = acquire aborted
//   job_id_o             job ID granted by acquire, held until the next completion
//   req_o, gnt_i         control-bus request / grant
//   add_o, wen_o         word address, 0 = write / 1 = read
//   be_o, data_o         byte enables, write data
//   r_data_i, r_valid_i  response data / response valid (reads and writes)

module hwpe_ctrl_offloader #(
    parameter int N_IO_REGS   = 2,
    parameter int N_CONTEXT   = 2,
    parameter int LOG_REGS    = 6,
    parameter int IO_BASE     = 16,
    parameter int MAX_RETRIES = 15,
    parameter int BACKOFF     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   job_valid_i,
    output logic                   job_ready_o,
    input  logic [N_IO_REGS*32-1:0] job_params_i,
    input  logic                   evt_i,
    output logic                   job_done_o,
    output logic                   job_err_o,
    output logic [7:0]             job_id_o,
    output logic                   req_o,
    input  logic                   gnt_i,
    output logic [31:0]            add_o,
    output logic                   wen_o,
    output logic [3:0]             be_o,
    output logic [31:0]            data_o,
    input  logic [31:0]            r_data_i,
    input  logic                   r_valid_i
);

    localparam int LOG_CONTEXT = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
    localparam int IDX_W       = (N_IO_REGS > 1) ? $clog2(N_IO_REGS) : 1;

    localparam logic [31:0] ADDR_TRIGGER  = 32'd0;
    localparam logic [31:0] ADDR_ACQUIRE  = 32'd1;
    localparam logic [31:0] ADDR_FINISHED = 32'd2;

    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_IO_REGS - 1);
    localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRIES);
    localparam logic [15:0]      BO_LOAD     = (BACKOFF > 0) ? 16'(BACKOFF - 1) : 16'd0;

    typedef enum logic [3:0] {
        IDLE,
        ACQ,
        ACQ_RSP,
        BACKOFF_ST,
        WR_IO,
        TRIG,
        WAIT_EVT,
        FIN,
        DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [N_IO_REGS*32-1:0]  params_q;
    logic [7:0]               retry_q;
    logic [15:0]              bo_cnt_q;
    logic [IDX_W-1:0]         idx_q;
    logic [LOG_CONTEXT-1:0]   ctx_q;
    logic [7:0]               id_q;
    logic [7:0]               job_id_q;
    logic                     err_q;
    logic                     evt_seen_q;
    // Set from grant until the matching r_valid_i; splits each bus state
    // into a request phase and a response phase.
    logic                     rsp_pend_q;

    logic                     acq_busy;
    logic [31:0]              ctx_mod;
    logic [31:0]              io_addr;

    assign acq_busy = (r_data_i == 32'hFFFF_FFFE) || (r_data_i == 32'hFFFF_FFFF);
    assign ctx_mod  = 32'(r_data_i[LOG_CONTEXT-1:0]) % 32'(N_CONTEXT);
    assign io_addr  = (32'(ctx_q) << LOG_REGS) + 32'(IO_BASE) + 32'(idx_q);

    assign job_id_o = job_id_q;

    // Next state and bus outputs. Outputs depend only on registered state,
    // so request fields stay stable until the grant.
    always_comb begin
        state_d     = state_q;
        job_ready_o = 1'b0;
        job_done_o  = 1'b0;
        job_err_o   = 1'b0;
        req_o       = 1'b0;
        add_o       = 32'd0;
        wen_o       = 1'b1;
        data_o      = 32'd0;
        be_o        = 4'h0;

        case (state_q)
            IDLE: begin
                job_ready_o = 1'b1;
                if (job_valid_i) begin
                    state_d = ACQ;
                end
            end
            ACQ: begin
                req_o = 1'b1;
                add_o = ADDR_ACQUIRE;
                if (gnt_i) begin
                    state_d = ACQ_RSP;
                end
            end
            ACQ_RSP: begin
                if (r_valid_i) begin
                    if (acq_busy) begin
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = DONE;
                        end else if (BACKOFF == 0) begin
                            state_d = ACQ;
                        end else begin
                            state_d = BACKOFF_ST;
                        end
                    end else begin
                        state_d = WR_IO;
                    end
                end
            end
            BACKOFF_ST: begin
                if (bo_cnt_q == 16'd0) begin
                    state_d = ACQ;
                end
            end
            WR_IO: begin
                if (!rsp_pend_q) begin
                    req_o  = 1'b1;
                    add_o  = io_addr;
                    wen_o  = 1'b0;
                    data_o = params_q[32*idx_q +: 32];
                end else if (r_valid_i && (idx_q == IDX_LAST)) begin
                    state_d = TRIG;
                end
            end
            TRIG: begin
                if (!rsp_pend_q) begin
                    req_o = 1'b1;
                    add_o = ADDR_TRIGGER;
                    wen_o = 1'b0;
                end else if (r_valid_i) begin
                    state_d = WAIT_EVT;
                end
            end
            WAIT_EVT: begin
                if (evt_i || evt_seen_q) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (!rsp_pend_q) begin
                    req_o = 1'b1;
                    add_o = ADDR_FINISHED;
                end else if (r_valid_i) begin
                    // A zero FINISHED means the event was spurious.
                    state_d = (r_data_i == 32'd0) ? WAIT_EVT : DONE;
                end
            end
            DONE: begin
                job_done_o = 1'b1;
                job_err_o  = err_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (req_o) begin
            be_o = 4'hF;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            params_q   <= '0;
            retry_q    <= 8'd0;
            bo_cnt_q   <= 16'd0;
            idx_q      <= '0;
            ctx_q      <= '0;
            id_q       <= 8'd0;
            job_id_q   <= 8'd0;
            err_q      <= 1'b0;
            evt_seen_q <= 1'b0;
            rsp_pend_q <= 1'b0;
        end else if (clear_i) begin
            state_q    <= IDLE;
            params_q   <= '0;
            retry_q    <= 8'd0;
            bo_cnt_q   <= 16'd0;
            idx_q      <= '0;
            ctx_q      <= '0;
            id_q       <= 8'd0;
            job_id_q   <= 8'd0;
            err_q      <= 1'b0;
            evt_seen_q <= 1'b0;
            rsp_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (req_o && gnt_i) begin
                rsp_pend_q <= 1'b1;
            end else if (rsp_pend_q && r_valid_i) begin
                rsp_pend_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (job_valid_i) begin
                        params_q   <= job_params_i;
                        retry_q    <= 8'd0;
                        id_q       <= 8'd0;
                        ctx_q      <= '0;
                        idx_q      <= '0;
                        err_q      <= 1'b0;
                        evt_seen_q <= 1'b0;
                    end
                end
                ACQ_RSP: begin
                    if (r_valid_i) begin
                        if (acq_busy) begin
                            if (retry_q == RETRY_LIMIT) begin
                                err_q <= 1'b1;
                            end else begin
                                if (retry_q != 8'hFF) begin
                                    retry_q <= retry_q + 8'd1;
                                end
                                bo_cnt_q <= BO_LOAD;
                            end
                        end else begin
                            id_q  <= r_data_i[7:0];
                            ctx_q <= LOG_CONTEXT'(ctx_mod);
                            idx_q <= '0;
                        end
                    end
                end
                BACKOFF_ST: begin
                    if (bo_cnt_q != 16'd0) begin
                        bo_cnt_q <= bo_cnt_q - 16'd1;
                    end
                end
                WR_IO: begin
                    if (rsp_pend_q && r_valid_i && (idx_q != IDX_LAST)) begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase

            // The HWPE can finish before the trigger write is acknowledged,
            // so an event seen while still writing is kept for WAIT_EVT.
            if (state_q == WAIT_EVT) begin
                evt_seen_q <= 1'b0;
            end else if (evt_i && ((state_q == WR_IO) || (state_q == TRIG) || (state_q == FIN))) begin
                evt_seen_q <= 1'b1;
            end

            if ((state_d == DONE) && (state_q != DONE)) begin
                job_id_q <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_offloader.sv
// tb/tb_hwpe_ctrl_offloader.sv - scoreboard bench for hwpe_ctrl_offloader

module tb_hwpe_ctrl_offloader;

    localparam int N_IO_REGS   = 2;
    localparam int N_CONTEXT   = 2;
    localparam int LOG_CONTEXT = 1;
    localparam int LOG_REGS    = 6;
    localparam int IO_BASE     = 16;
    localparam int MAX_RETRIES = 15;
    localparam int BACKOFF     = 8;

    typedef struct { logic [31:0] add; logic wen; logic [31:0] data; } bus_t;
    typedef struct { logic err; logic [7:0] id; } done_t;

    logic                    clk_i = 1'b0;
    logic                    rst_ni = 1'b1;
    logic                    clear_i = 1'b0;
    logic                    job_valid_i = 1'b0;
    logic                    job_ready_o;
    logic [N_IO_REGS*32-1:0] job_params_i = '0;
    logic                    evt_i = 1'b0;
    logic                    job_done_o;
    logic                    job_err_o;
    logic [7:0]              job_id_o;
    logic                    req_o;
    logic                    gnt_i = 1'b0;
    logic [31:0]             add_o;
    logic                    wen_o;
    logic [3:0]              be_o;
    logic [31:0]             data_o;
    logic [31:0]             r_data_i = 32'd0;
    logic                    r_valid_i = 1'b0;

    hwpe_ctrl_offloader #(
        .N_IO_REGS(N_IO_REGS), .N_CONTEXT(N_CONTEXT), .LOG_REGS(LOG_REGS),
        .IO_BASE(IO_BASE), .MAX_RETRIES(MAX_RETRIES), .BACKOFF(BACKOFF)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_params_i(job_params_i),
        .evt_i(evt_i), .job_done_o(job_done_o), .job_err_o(job_err_o), .job_id_o(job_id_o),
        .req_o(req_o), .gnt_i(gnt_i), .add_o(add_o), .wen_o(wen_o), .be_o(be_o),
        .data_o(data_o), .r_data_i(r_data_i), .r_valid_i(r_valid_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    bus_t        exp_bus_q[$];
    done_t       exp_done_q[$];
    logic [31:0] acq_rsp_q[$];
    logic [31:0] fin_rsp_q[$];

    logic [31:0] tmp_par[N_IO_REGS];
    logic [31:0] tmp_acq[$];
    logic [31:0] tmp_fin[$];

    // bus environment state
    int          cyc = 0;
    bit          outstanding = 0;
    int          rsp_timer = 0;
    logic [31:0] rsp_data = 0;
    int          rsp_kind = 0;
    bit          in_req = 0;
    logic [31:0] h_add, h_data;
    logic        h_wen;
    logic [3:0]  h_be;
    int          stall_left = 0;
    bit          stalled = 0;
    bit          hold_bad = 0;
    int          evt_timer = -1;
    bit          busy_pending = 0;
    int          busy_rv_cyc = 0;
    int          stall_fixed = -1;
    int          rsp_delay_fixed = -1;
    int          proto_err = 0;
    int          done_count = 0;
    bit          wr_gnt_seen = 0;
    bit          prev_done = 0;
    logic [7:0]  last_id = 8'd0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Bus slave plus monitor: grants, responds, raises events and scores
    // every granted transaction and every completion against the queues.
    always begin
        done_t d;
        bus_t  e;
        @(posedge clk_i);
        #1;
        cyc++;
        gnt_i     = 1'b0;
        r_valid_i = 1'b0;
        evt_i     = 1'b0;
        r_data_i  = $urandom;
        if (rst_ni) begin
            if (evt_timer == 0) begin
                evt_i = 1'b1;
                evt_timer = -1;
            end else if (evt_timer > 0) begin
                evt_timer--;
            end
            if (prev_done) begin
                check_eq("ready_after_done", 32'(job_ready_o), 32'd1);
                if (job_done_o) proto_err++;
            end
            if (!job_done_o && job_id_o !== last_id) proto_err++;

            if (outstanding) begin
                if (req_o) proto_err++;
                rsp_timer--;
                if (rsp_timer == 0) begin
                    r_valid_i   = 1'b1;
                    r_data_i    = rsp_data;
                    outstanding = 0;
                    if (rsp_kind == 1 && rsp_data >= 32'hFFFF_FFFE) begin
                        busy_pending = 1;
                        busy_rv_cyc  = cyc;
                    end
                    if (rsp_kind == 2 && rsp_data == 32'd0) evt_timer = $urandom_range(1, 4);
                end
            end else if (req_o) begin
                if (!in_req) begin
                    in_req = 1;
                    h_add = add_o; h_wen = wen_o; h_data = data_o; h_be = be_o;
                    stall_left = (stall_fixed >= 0) ? stall_fixed : $urandom_range(0, 2);
                    stalled  = (stall_left > 0);
                    hold_bad = 0;
                    if (busy_pending) begin
                        check_eq("backoff_gap", 32'(cyc - busy_rv_cyc), 32'(BACKOFF + 1));
                        busy_pending = 0;
                    end
                end else if (add_o !== h_add || wen_o !== h_wen || data_o !== h_data || be_o !== h_be) begin
                    hold_bad = 1;
                end
                if (stall_left == 0) begin
                    gnt_i       = 1'b1;
                    in_req      = 0;
                    outstanding = 1;
                    rsp_timer   = (rsp_delay_fixed > 0) ? rsp_delay_fixed : $urandom_range(1, 3);
                    if (stalled) check_eq("hold_stable", 32'(hold_bad), 32'd0);
                    check_eq("be", 32'(be_o), 32'hF);
                    if (exp_bus_q.size() == 0) begin
                        fail_now("unexpected_txn");
                    end else begin
                        e = exp_bus_q.pop_front();
                        check_eq("txn_addr", add_o, e.add);
                        check_eq("txn_wen", 32'(wen_o), 32'(e.wen));
                        if (!e.wen) check_eq("txn_wdata", data_o, e.data);
                    end
                    rsp_kind = 0;
                    rsp_data = 32'd0;
                    if (wen_o && add_o == 32'd1) begin
                        rsp_kind = 1;
                        if (acq_rsp_q.size() > 0) rsp_data = acq_rsp_q.pop_front();
                    end else if (wen_o && add_o == 32'd2) begin
                        rsp_kind = 2;
                        if (fin_rsp_q.size() > 0) rsp_data = fin_rsp_q.pop_front();
                    end
                    if (!wen_o && add_o == 32'd0) evt_timer = $urandom_range(0, 4);
                    if (!wen_o && add_o != 32'd0) wr_gnt_seen = 1;
                end else begin
                    stall_left--;
                end
            end

            if (job_done_o) begin
                if (exp_done_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    d = exp_done_q.pop_front();
                    check_eq("done_err", 32'(job_err_o), 32'(d.err));
                    if (!d.err) check_eq("done_id", 32'(job_id_o), 32'(d.id));
                    check_eq("txns_left_at_done", 32'(exp_bus_q.size()), 32'd0);
                    check_eq("protocol", 32'(proto_err), 32'd0);
                end
                proto_err    = 0;
                busy_pending = 0;
                last_id      = job_id_o;
                done_count++;
            end
            prev_done = job_done_o;
        end
    end

    // Reference model: turns a job description into the bus transactions and
    // completion it must produce, and queues the slave's responses.
    task automatic push_job();
        int         busy_n = 0;
        bit         aborted = 0;
        logic [7:0] id = 8'd0;
        int         ctx;
        done_t      d;
        foreach (tmp_acq[i]) begin
            exp_bus_q.push_back('{32'd1, 1'b1, 32'd0});
            acq_rsp_q.push_back(tmp_acq[i]);
            if (tmp_acq[i] >= 32'hFFFF_FFFE) begin
                busy_n++;
                if (busy_n > MAX_RETRIES) begin
                    aborted = 1;
                    break;
                end
            end else begin
                id = tmp_acq[i][7:0];
                break;
            end
        end
        if (aborted) begin
            d = '{1'b1, 8'd0};
            exp_done_q.push_back(d);
            return;
        end
        ctx = (int'(id) % (1 << LOG_CONTEXT)) % N_CONTEXT;
        for (int k = 0; k < N_IO_REGS; k++)
            exp_bus_q.push_back('{32'(ctx * (1 << LOG_REGS) + IO_BASE + k), 1'b0, tmp_par[k]});
        exp_bus_q.push_back('{32'd0, 1'b0, 32'd0});
        foreach (tmp_fin[i]) begin
            exp_bus_q.push_back('{32'd2, 1'b1, 32'd0});
            fin_rsp_q.push_back(tmp_fin[i]);
            if (tmp_fin[i] != 32'd0) break;
        end
        d = '{1'b0, id};
        exp_done_q.push_back(d);
    endtask

    task automatic cyc_wait();
        @(posedge clk_i);
        #2;
    endtask

    task automatic accept_job();
        int to = 0;
        while (!job_ready_o && to < 200) begin
            cyc_wait();
            to++;
        end
        if (to >= 200) fail_now("ready_timeout");
        for (int k = 0; k < N_IO_REGS; k++) job_params_i[32*k +: 32] = tmp_par[k];
        job_valid_i = 1'b1;
        cyc_wait();
        job_valid_i  = 1'b0;
        job_params_i = {N_IO_REGS{$urandom}};
    endtask

    task automatic run_job();
        int target = done_count + 1;
        int to = 0;
        push_job();
        accept_job();
        // a request while busy must be ignored
        repeat (3) cyc_wait();
        job_valid_i = 1'b1;
        cyc_wait();
        job_valid_i = 1'b0;
        while (done_count < target && to < 3000) begin
            cyc_wait();
            to++;
        end
        if (to >= 3000) fail_now("job_timeout");
        repeat (2) cyc_wait();
    endtask

    task automatic gen_random();
        int          nb, nz;
        logic [31:0] v;
        tmp_acq.delete();
        tmp_fin.delete();
        for (int k = 0; k < N_IO_REGS; k++) tmp_par[k] = $urandom;
        nb = $urandom_range(0, 3);
        for (int i = 0; i < nb; i++) tmp_acq.push_back($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
        v = $urandom;
        if (v >= 32'hFFFF_FFFE) v = 32'd5;
        tmp_acq.push_back(v);
        nz = $urandom_range(0, 2);
        for (int i = 0; i < nz; i++) tmp_fin.push_back(32'd0);
        tmp_fin.push_back($urandom | 32'd1);
    endtask

    task automatic set_nominal(input logic [31:0] acq_id);
        tmp_acq.delete();
        tmp_fin.delete();
        tmp_par[0] = 32'hA;
        tmp_par[1] = 32'hB;
        tmp_acq.push_back(acq_id);
        tmp_fin.push_back(32'd1);
    endtask

    initial begin
        int to;
        int dc;
        #1 rst_ni = 1'b0;
        #11;
        check_eq("rst_req", 32'(req_o), 32'd0);
        check_eq("rst_wen", 32'(wen_o), 32'd1);
        check_eq("rst_be", 32'(be_o), 32'd0);
        check_eq("rst_add", add_o, 32'd0);
        check_eq("rst_data", data_o, 32'd0);
        check_eq("rst_done", 32'(job_done_o), 32'd0);
        check_eq("rst_err", 32'(job_err_o), 32'd0);
        check_eq("rst_id", 32'(job_id_o), 32'd0);
        repeat (2) cyc_wait();
        rst_ni = 1'b1;
        cyc_wait();
        check_eq("ready_after_reset", 32'(job_ready_o), 32'd1);

        // nominal, ID 0x03 -> context 1
        set_nominal(32'h03);
        run_job();

        // two busy responses then ID 0 -> context 0, backoff gaps scored
        set_nominal(32'h00);
        tmp_acq.delete();
        tmp_acq.push_back(32'hFFFF_FFFF);
        tmp_acq.push_back(32'hFFFF_FFFF);
        tmp_acq.push_back(32'h00);
        run_job();

        // abort after MAX_RETRIES+1 busy reads
        gen_random();
        tmp_acq.delete();
        for (int i = 0; i < MAX_RETRIES + 1; i++) tmp_acq.push_back(32'hFFFF_FFFE);
        run_job();

        // grant stall of 5 cycles on every transaction
        stall_fixed = 5;
        gen_random();
        run_job();
        stall_fixed = -1;

        // spurious event: FINISHED reads 0 then 1
        set_nominal(32'h07);
        tmp_fin.delete();
        tmp_fin.push_back(32'd0);
        tmp_fin.push_back(32'd1);
        run_job();

        for (int j = 0; j < 20; j++) begin
            gen_random();
            run_job();
        end

        // clear during the IO write data phase
        set_nominal(32'h03);
        push_job();
        rsp_delay_fixed = 4;
        wr_gnt_seen = 0;
        dc = done_count;
        accept_job();
        to = 0;
        while (!wr_gnt_seen && to < 500) begin
            cyc_wait();
            to++;
        end
        if (!wr_gnt_seen) fail_now("clear_no_io_write");
        cyc_wait();
        clear_i = 1'b1;
        last_id = 8'd0;
        cyc_wait();
        clear_i = 1'b0;
        check_eq("clear_ready", 32'(job_ready_o), 32'd1);
        check_eq("clear_req", 32'(req_o), 32'd0);
        check_eq("clear_wen", 32'(wen_o), 32'd1);
        exp_bus_q.delete();
        exp_done_q.delete();
        acq_rsp_q.delete();
        fin_rsp_q.delete();
        evt_timer = -1;
        repeat (8) cyc_wait();
        check_eq("late_rvalid_ready", 32'(job_ready_o), 32'd1);
        check_eq("late_rvalid_req", 32'(req_o), 32'd0);
        check_eq("clear_no_done", 32'(done_count), 32'(dc));
        rsp_delay_fixed = -1;

        gen_random();
        run_job();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
